// File: rtl/ws281x_pkg.sv
// rtl/ws281x_pkg.sv - shared timing defaults, widths and FSM encoding for the WS281X receiver
package ws281x_pkg;

    localparam int unsigned T_THRESH_DEF   = 23;
    localparam int unsigned T_MAXHIGH_DEF  = 50;
    localparam int unsigned T_LATCH_DEF    = 2500;
    localparam int unsigned BITS_PER_PIXEL = 24;

    localparam int unsigned HIGH_CNT_W = 6;
    localparam int unsigned LOW_CNT_W  = 12;
    localparam int unsigned BIT_CNT_W  = 5;
    localparam int unsigned PIX_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_RESYNC
    } rx_state_e;

endpackage

// File: rtl/ws281x_pulse_timer.sv
// rtl/ws281x_pulse_timer.sv - Din synchroniser, edge detect and saturating high/low time counters
module ws281x_pulse_timer
    import ws281x_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  din_i,
    output logic                  din_s_o,
    output logic                  rise_o,
    output logic                  fall_o,
    output logic [HIGH_CNT_W-1:0] high_cnt_o,
    output logic [LOW_CNT_W-1:0]  low_cnt_o
);

    // [1:0] is the two-flop synchroniser, [2] the previous synchronised sample
    logic [2:0]            sync_q;
    logic                  din_s;
    logic                  rise;
    logic                  fall;
    logic [HIGH_CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [LOW_CNT_W-1:0]  low_cnt_q, low_cnt_d;

    assign din_s = sync_q[1];
    assign rise  = din_s & ~sync_q[2];
    assign fall  = ~din_s & sync_q[2];

    // Counters restart at 1 on the edge cycle so their value equals the level time in clocks
    always_comb begin
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        if (rise) begin
            high_cnt_d = HIGH_CNT_W'(1);
        end else if (din_s && (high_cnt_q != '1)) begin
            high_cnt_d = high_cnt_q + HIGH_CNT_W'(1);
        end
        if (fall) begin
            low_cnt_d = LOW_CNT_W'(1);
        end else if (!din_s && (low_cnt_q != '1)) begin
            low_cnt_d = low_cnt_q + LOW_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
        end else begin
            sync_q     <= {sync_q[1:0], din_i};
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
        end
    end

    assign din_s_o    = din_s;
    assign rise_o     = rise;
    assign fall_o     = fall;
    assign high_cnt_o = high_cnt_q;
    assign low_cnt_o  = low_cnt_q;

endmodule

// File: rtl/ws281x_rx.sv
// rtl/ws281x_rx.sv - WS281X serial stream decoder producing GRB pixels with frame sync and error strobes
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int unsigned T_THRESH  = T_THRESH_DEF,
    parameter int unsigned T_MAXHIGH = T_MAXHIGH_DEF,
    parameter int unsigned T_LATCH   = T_LATCH_DEF
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Din,
    output logic [BITS_PER_PIXEL-1:0] Pixel,
    output logic                      Valid,
    output logic [PIX_CNT_W-1:0]      PixelNum,
    output logic                      Sync,
    output logic                      Error
);

    localparam logic [HIGH_CNT_W-1:0] THRESH_C   = HIGH_CNT_W'(T_THRESH);
    localparam logic [HIGH_CNT_W-1:0] MAXHIGH_C  = HIGH_CNT_W'(T_MAXHIGH);
    localparam logic [LOW_CNT_W-1:0]  LATCH_C    = LOW_CNT_W'(T_LATCH);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT_C = BIT_CNT_W'(BITS_PER_PIXEL - 1);

    logic                      din_s;
    logic                      rise;
    logic                      fall;
    logic [HIGH_CNT_W-1:0]     high_cnt;
    logic [LOW_CNT_W-1:0]      low_cnt;
    logic                      bit_val;

    rx_state_e                 state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PIX_CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
    logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
    logic [PIX_CNT_W-1:0]      pixel_num_q, pixel_num_d;
    logic                      valid_q, valid_d;
    logic                      sync_q, sync_d;
    logic                      error_q, error_d;

    ws281x_pulse_timer u_timer (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .din_i      (Din),
        .din_s_o    (din_s),
        .rise_o     (rise),
        .fall_o     (fall),
        .high_cnt_o (high_cnt),
        .low_cnt_o  (low_cnt)
    );

    assign bit_val = (high_cnt >= THRESH_C);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        pixel_d     = pixel_q;
        pixel_num_d = pixel_num_q;
        valid_d     = 1'b0;
        sync_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                // Overlong check first: a pulse of exactly T_MAXHIGH+1 is only visible on its fall cycle
                if (high_cnt > MAXHIGH_C) begin
                    error_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_RESYNC;
                end else if (fall) begin
                    shift_d = {shift_q[BITS_PER_PIXEL-2:0], bit_val};
                    state_d = ST_LOW;
                    if (bit_cnt_q == LAST_BIT_C) begin
                        bit_cnt_d   = '0;
                        pixel_d     = shift_d;
                        valid_d     = 1'b1;
                        pixel_num_d = pix_cnt_q;
                        if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_LOW: begin
                if (low_cnt >= LATCH_C) begin
                    sync_d      = 1'b1;
                    error_d     = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    pixel_num_d = '0;
                    state_d     = rise ? ST_HIGH : ST_IDLE;
                end else if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_RESYNC: begin
                if (!din_s && (low_cnt >= LATCH_C)) begin
                    bit_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    pixel_num_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            pixel_q     <= '0;
            pixel_num_q <= '0;
            valid_q     <= 1'b0;
            sync_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            pixel_q     <= pixel_d;
            pixel_num_q <= pixel_num_d;
            valid_q     <= valid_d;
            sync_q      <= sync_d;
            error_q     <= error_d;
        end
    end

    assign Pixel    = pixel_q;
    assign Valid    = valid_q;
    assign PixelNum = pixel_num_q;
    assign Sync     = sync_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_ws281x_rx.sv
// tb/tb_ws281x_rx.sv - self-checking bench for ws281x_rx against a pulse-width reference model
module tb_ws281x_rx;

    localparam int THRESH  = 23;
    localparam int MAXHIGH = 50;
    localparam int LATCH   = 2500;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Din;
    logic [23:0] Pixel;
    logic        Valid;
    logic [7:0]  PixelNum;
    logic        Sync;
    logic        Error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fall_cyc = 0;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  num;
        int          cyc;
    } vev_t;

    typedef struct {
        int   hi;
        logic exp_bit;
    } bvec_t;

    vev_t vq[$];
    int   sq[$];
    int   eq[$];
    logic pv = 1'b0, ps = 1'b0, pe = 1'b0;

    ws281x_rx dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Din      (Din),
        .Pixel    (Pixel),
        .Valid    (Valid),
        .PixelNum (PixelNum),
        .Sync     (Sync),
        .Error    (Error)
    );

    always #10ns Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (Valid) begin
            vq.push_back('{pix: Pixel, num: PixelNum, cyc: cyc});
            chk("valid_one_cycle", pv, 0);
        end
        if (Sync) begin
            sq.push_back(cyc);
            chk("sync_one_cycle", ps, 0);
        end
        if (Error) begin
            eq.push_back(cyc);
            chk("error_one_cycle", pe, 0);
        end
        pv <= Valid;
        ps <= Sync;
        pe <= Error;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic model_bit(input int hi);
        return (hi >= THRESH);
    endfunction

    function automatic int model_num(input int idx);
        return (idx > 255) ? 255 : idx;
    endfunction

    task automatic bit_clk(input int hi, input int lo);
        Din = 1'b1;
        repeat (hi) @(negedge Clock);
        Din = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo) @(negedge Clock);
    endtask

    task automatic bit_ns(input logic b);
        Din = 1'b1;
        if (b) #625ns; else #250ns;
        Din = 1'b0;
        last_fall_cyc = cyc;
        if (b) #625ns; else #1000ns;
    endtask

    task automatic latch_gap();
        Din = 1'b0;
        repeat (LATCH + 20) @(negedge Clock);
    endtask

    task automatic clear_log();
        vq.delete();
        sq.delete();
        eq.delete();
    endtask

    task automatic pixel_clk(input logic [23:0] p, input int lo);
        for (int b = 23; b >= 0; b--) bit_clk(p[b] ? 30 : 5, lo);
    endtask

    bvec_t       tbl[7];
    logic [23:0] stream[7];
    logic [23:0] exp_pix[260];
    logic [23:0] acc;
    logic [22:0] prefix;
    logic [23:0] word;
    int          hi, lo, n, gap;

    initial begin
        tbl[0] = '{hi: 1,  exp_bit: 1'b0};
        tbl[1] = '{hi: 12, exp_bit: 1'b0};
        tbl[2] = '{hi: 22, exp_bit: 1'b0};
        tbl[3] = '{hi: 23, exp_bit: 1'b1};
        tbl[4] = '{hi: 30, exp_bit: 1'b1};
        tbl[5] = '{hi: 31, exp_bit: 1'b1};
        tbl[6] = '{hi: 50, exp_bit: 1'b1};
        stream = '{24'hAA0000, 24'h00BB00, 24'h0000CC, 24'h555555,
                   24'h000000, 24'hFFFFFF, 24'h123456};
        prefix = 23'h55AA33;

        Reset = 1'b1;
        Din   = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_pixel", Pixel, 0);
        chk("reset_valid", Valid, 0);
        chk("reset_pixelnum", PixelNum, 0);
        chk("reset_sync", Sync, 0);
        chk("reset_error", Error, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // Boundary table: 23 fixed bits then one bit of the tabulated high time
        for (int k = 0; k < 7; k++) begin
            clear_log();
            acc = '0;
            for (int b = 22; b >= 0; b--) begin
                hi  = prefix[b] ? 30 : 5;
                acc = {acc[22:0], model_bit(hi)};
                bit_clk(hi, 8);
            end
            acc = {acc[22:0], model_bit(tbl[k].hi)};
            bit_clk(tbl[k].hi, 8);
            chk("tbl_valid_count", vq.size(), 1);
            if (vq.size() > 0) begin
                chk("tbl_pixel", vq[0].pix, acc);
                chk("tbl_bit", vq[0].pix[0], tbl[k].exp_bit);
                chk("tbl_pixelnum", vq[0].num, k);
                chk("tbl_latency", vq[0].cyc - last_fall_cyc, 3);
            end
            chk("tbl_no_error", eq.size(), 0);
        end
        clear_log();
        latch_gap();
        chk("tbl_sync_count", sq.size(), 1);
        chk("tbl_latch_error", eq.size(), 0);

        // Seven-pixel stream with real WS281X timing
        clear_log();
        #888ns;
        for (int p = 0; p < 7; p++)
            for (int b = 23; b >= 0; b--) bit_ns(stream[p][b]);
        Din = 1'b0;
        #52000ns;
        @(negedge Clock);
        chk("stream_valid_count", vq.size(), 7);
        for (int i = 0; i < 7 && i < vq.size(); i++) begin
            chk("stream_pixel", vq[i].pix, stream[i]);
            chk("stream_pixelnum", vq[i].num, i);
        end
        chk("stream_sync_count", sq.size(), 1);
        if (sq.size() > 0) begin
            gap = sq[0] - last_fall_cyc;
            chk("stream_sync_delay_ok", (gap >= LATCH) && (gap <= LATCH + 10), 1);
        end
        chk("stream_error_count", eq.size(), 0);

        // Overlong pulse mid-pixel, recovery after a latch
        clear_log();
        for (int b = 0; b < 10; b++) bit_clk(b[0] ? 30 : 5, 10);
        bit_clk(MAXHIGH + 5, 0);
        latch_gap();
        chk("long_error_count", eq.size(), 1);
        chk("long_valid_count", vq.size(), 0);
        chk("long_resync_no_sync", sq.size(), 0);
        pixel_clk(24'h123456, 10);
        latch_gap();
        chk("recover_valid_count", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("recover_pixel", vq[0].pix, 24'h123456);
            chk("recover_pixelnum", vq[0].num, 0);
        end
        chk("recover_sync_count", sq.size(), 1);
        chk("recover_error_count", eq.size(), 1);

        // Partial pixel at latch
        clear_log();
        for (int b = 0; b < 10; b++) bit_clk(b[1] ? 30 : 5, 10);
        latch_gap();
        chk("partial_sync_count", sq.size(), 1);
        chk("partial_error_count", eq.size(), 1);
        if (sq.size() > 0 && eq.size() > 0) chk("partial_same_cycle", eq[0], sq[0]);
        chk("partial_valid_count", vq.size(), 0);
        chk("partial_pixelnum", PixelNum, 0);

        // Reset mid-pixel
        clear_log();
        word = 24'hAA0000;
        for (int b = 23; b >= 12; b--) bit_clk(word[b] ? 30 : 5, 10);
        #3ns;
        Reset = 1'b1;
        #1ns;
        chk("midreset_pixel", Pixel, 0);
        chk("midreset_valid", Valid, 0);
        chk("midreset_pixelnum", PixelNum, 0);
        chk("midreset_sync", Sync, 0);
        chk("midreset_error", Error, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        pixel_clk(24'h00BB00, 10);
        latch_gap();
        chk("postreset_valid_count", vq.size(), 1);
        if (vq.size() > 0) begin
            chk("postreset_pixel", vq[0].pix, 24'h00BB00);
            chk("postreset_pixelnum", vq[0].num, 0);
        end

        // Randomized frame: each bit gets a random legal high time, model decides the bit
        clear_log();
        n = $urandom_range(3, 5);
        for (int p = 0; p < n; p++) begin
            acc = '0;
            for (int b = 0; b < 24; b++) begin
                hi  = $urandom_range(1, MAXHIGH);
                lo  = $urandom_range(1, 30);
                acc = {acc[22:0], model_bit(hi)};
                bit_clk(hi, lo);
            end
            exp_pix[p] = acc;
        end
        repeat (5) @(negedge Clock);
        latch_gap();
        chk("rand_valid_count", vq.size(), n);
        for (int i = 0; i < n && i < vq.size(); i++) begin
            chk("rand_pixel", vq[i].pix, exp_pix[i]);
            chk("rand_pixelnum", vq[i].num, i);
        end
        chk("rand_sync_count", sq.size(), 1);
        chk("rand_error_count", eq.size(), 0);

        // 260 pixels in one frame: index saturates at 255
        clear_log();
        for (int p = 0; p < 260; p++) begin
            word = 24'(p % 16);
            acc  = '0;
            for (int b = 23; b >= 0; b--) begin
                hi  = word[b] ? THRESH : 1;
                acc = {acc[22:0], model_bit(hi)};
                bit_clk(hi, 1);
            end
            exp_pix[p] = acc;
        end
        repeat (5) @(negedge Clock);
        latch_gap();
        chk("sat_valid_count", vq.size(), 260);
        for (int i = 0; i < 260 && i < vq.size(); i++) begin
            chk("sat_pixel", vq[i].pix, exp_pix[i]);
            chk("sat_pixelnum", vq[i].num, model_num(i));
        end
        chk("sat_sync_count", sq.size(), 1);
        chk("sat_error_count", eq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
